seq_shift_extend: RTL and testbench
===================================

# seq_shift_extend

Iterative, parametrised shift-and-extend unit for the multicycle datapath. It generalises the fixed shift-left-by-2, 16-to-32 zero extension and field concatenation into one configurable block. The block takes a register operand or an immediate, applies a zero/sign extension and a shift of runtime-selected amount and direction, and processes STEP bits per cycle under a start/done handshake. It feeds branch-target, jump-target and shift-instruction results into the ALU result mux.

## Interface
- WIDTH, 32: datapath width; must be a power of two, at least 8.
- IMM_W, 16: immediate field width; must be less than WIDTH.
- STEP, 1: bit positions shifted per cycle; range 1..WIDTH.
- clk  in  1  rising-edge clock; the block uses only this one clock.
- rst  in  1  reset; synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- op  in  3  operation code.
- data_in  in  WIDTH  register operand.
- imm_in  in  IMM_W  immediate operand.
- shamt  in  clog2(WIDTH)  shift amount, unsigned.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  registered result; held until the next completion.

## Operation
- Op codes:
  - 000 SLL data_in.
  - 001 SRL data_in.
  - 010 SRA data_in.
  - 011 ZEXT: zero-extend imm_in to WIDTH, then shift left.
  - 100 SEXT: sign-extend imm_in to WIDTH, then shift left.
  - 101 ROR data_in (only with the macro; see Configuration).
  - 110, 111: illegal.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, start=1:
  - Latch op and remaining count = shamt.
  - Load the accumulator with data_in, or with the extended imm_in for ZEXT/SEXT.
  - If shamt=0 or op is illegal, go to DONE with result = loaded value; otherwise go to SHIFT.
- SHIFT, each cycle:
  - k = min(STEP, remaining). Shift the accumulator by k; remaining -= k.
  - SRA fills with the latched original MSB.
  - When remaining ≤ STEP at cycle start, write result with the final value and go to DONE.
- DONE: done=1 for exactly one cycle, then return to IDLE.
- start in SHIFT or DONE is ignored (no queuing). Inputs other than start are don't-care after the start cycle.
- Illegal op: the zero-shift path; result = data_in.
- Shift arithmetic is modulo WIDTH bit positions; shamt never exceeds WIDTH-1.

## Timing
- Reset values: busy=0, done=0, result=0, state=IDLE, accumulator=0, count=0.
- start sampled at edge 1 → done high after edge 1+ceil(shamt/STEP), for one cycle.
- result changes only on the edge that enters DONE. It is stable while done=1 and afterwards.
- Maximum back-to-back rate: next start accepted the cycle after done falls (state IDLE).
- rst asserted mid-SHIFT or during DONE: at that edge state=IDLE, busy=0, done=0, result=0. A start in the same cycle as rst is discarded.

## Configuration
- SEQ_SHIFT_ROTATE_EN defined:
  - Op 101 is ROR data_in; bits shifted out of the LSB re-enter at the MSB.
  - Latency matches the other shifts.
- SEQ_SHIFT_ROTATE_EN undefined:
  - Op 101 is illegal, same as 110/111.
  - No rotate datapath is synthesised.

## Structure
- Package seq_shift_pkg holds:
  - op-code localparams (OP_SLL, OP_SRL, OP_SRA, OP_ZEXT, OP_SEXT, OP_ROR);
  - the state enum (ST_IDLE, ST_SHIFT, ST_DONE);
  - a clog2 helper constant function.
- Sub-module imm_extend (combinational, parameters IMM_W and WIDTH, input sign_sel) produces the extended immediate. The FSM, counter and accumulator stay in the top module.

## Test plan
- SLL, WIDTH=32, STEP=1, data_in=0x00000001, shamt=31, start at edge 1 → done after edge 32, result=0x80000000, busy high edges 1–32.
- SRA, data_in=0x80000000, shamt=4 → result=0xF8000000, done after edge 5. Repeat with SRL → 0x08000000.
- SEXT, imm_in=0xFFFC, shamt=2 → result=0xFFFFFFF0. ZEXT, imm_in=0x8000, shamt=0 → result=0x00008000, done after edge 1.
- STEP=4, SLL, data_in=0x1, shamt=5 → two SHIFT cycles, done after edge 3, result=0x00000020.
- Second start issued mid-SHIFT with different operands is ignored. Then rst mid-SHIFT → next cycle busy=0, done=0, result=0, and no done pulse follows.
- With SEQ_SHIFT_ROTATE_EN, op 101, data_in=0x00000003, shamt=1 → result=0x80000001. Without the macro → result=0x00000003, done after edge 1.

Source files
------------

// File: rtl/seq_shift_pkg.sv
// Shared definitions for the iterative shift-and-extend unit:
// op codes, FSM state encoding and a constant clog2 helper.
package seq_shift_pkg;

  localparam int unsigned OP_W = 3;

  localparam logic [OP_W-1:0] OP_SLL  = 3'b000;
  localparam logic [OP_W-1:0] OP_SRL  = 3'b001;
  localparam logic [OP_W-1:0] OP_SRA  = 3'b010;
  localparam logic [OP_W-1:0] OP_ZEXT = 3'b011;
  localparam logic [OP_W-1:0] OP_SEXT = 3'b100;
  localparam logic [OP_W-1:0] OP_ROR  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Number of bits needed to index 'value' positions (clog2(1) = 0).
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned v = value - 1; v > 0; v = v >> 1) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/imm_extend.sv
// Combinational immediate extension: zero-extend, or sign-extend when
// sign_sel is set, from IMM_W to WIDTH bits.
module imm_extend #(
  parameter int unsigned IMM_W = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic [IMM_W-1:0] imm,
  input  logic             sign_sel,
  output logic [WIDTH-1:0] imm_ext_c
);

  localparam int unsigned PAD_W = WIDTH - IMM_W;

  // Replicate either zero or the immediate MSB into the upper bits.
  always_comb begin
    imm_ext_c = {{PAD_W{sign_sel & imm[IMM_W-1]}}, imm};
  end

endmodule

// File: rtl/seq_shift_extend.sv
// Iterative shift-and-extend unit. Shifts a register operand or an
// extended immediate by a runtime amount, STEP bit positions per cycle,
// under a start/done handshake.
// Optional feature macro: SEQ_SHIFT_ROTATE_EN enables op 101 (rotate right);
// without it op 101 is treated as illegal and no rotate path exists.
module seq_shift_extend
  import seq_shift_pkg::*;
#(
  parameter  int unsigned WIDTH = 32,
  parameter  int unsigned IMM_W = 16,
  parameter  int unsigned STEP  = 1,
  localparam int unsigned SHW   = clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data_in,
  input  logic [IMM_W-1:0] imm_in,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  // One extra bit so STEP = WIDTH is representable in the counter domain.
  localparam int unsigned CNT_W = SHW + 1;
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(STEP);

`ifdef SEQ_SHIFT_ROTATE_EN
  localparam bit ROR_EN = 1'b1;
`else
  localparam bit ROR_EN = 1'b0;
`endif

  state_t           state;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q;

  logic             sign_sel_c;
  logic [WIDTH-1:0] imm_ext_c;
  logic [WIDTH-1:0] load_c;
  logic             legal_c;
  logic [CNT_W-1:0] k_c;
  logic [WIDTH-1:0] acc_next_c;

  // Immediate is sign-extended only for SEXT.
  always_comb begin
    sign_sel_c = (op == OP_SEXT);
  end

  imm_extend #(
    .IMM_W (IMM_W),
    .WIDTH (WIDTH)
  ) u_imm_extend (
    .imm       (imm_in),
    .sign_sel  (sign_sel_c),
    .imm_ext_c (imm_ext_c)
  );

  // Select the initial accumulator value and classify the op code.
  always_comb begin
    load_c  = data_in;
    legal_c = 1'b0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: legal_c = 1'b1;
      OP_ZEXT, OP_SEXT: begin
        legal_c = 1'b1;
        load_c  = imm_ext_c;
      end
      OP_ROR:  legal_c = ROR_EN;
      default: legal_c = 1'b0;
    endcase
  end

  // One iteration of the shift: k = min(STEP, remaining) positions.
  always_comb begin
    k_c        = (cnt_q < STEP_C) ? cnt_q : STEP_C;
    acc_next_c = acc_q;
    case (op_q)
      OP_SLL, OP_ZEXT, OP_SEXT: acc_next_c = acc_q << k_c;
      OP_SRL:                   acc_next_c = acc_q >> k_c;
      OP_SRA:                   acc_next_c = WIDTH'({{WIDTH{sign_q}}, acc_q} >> k_c);
`ifdef SEQ_SHIFT_ROTATE_EN
      OP_ROR:                   acc_next_c = WIDTH'({acc_q, acc_q} >> k_c);
`endif
      default:                  acc_next_c = acc_q;
    endcase
  end

  // Control FSM with registered busy/done/result and the datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      op_q   <= '0;
      acc_q  <= '0;
      cnt_q  <= '0;
      sign_q <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q   <= op;
            cnt_q  <= CNT_W'(shamt);
            acc_q  <= load_c;
            sign_q <= load_c[WIDTH-1];
            busy   <= 1'b1;
            if ((shamt == '0) || !legal_c) begin
              result <= load_c;
              done   <= 1'b1;
              state  <= ST_DONE;
            end else begin
              state  <= ST_SHIFT;
            end
          end
        end
        ST_SHIFT: begin
          acc_q <= acc_next_c;
          cnt_q <= cnt_q - k_c;
          if (cnt_q <= STEP_C) begin
            result <= acc_next_c;
            done   <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shift_extend.sv
// Self-checking bench for seq_shift_extend: a STEP=1 instance (a) and a
// STEP=4 instance (b) share operand inputs but have separate start lines.
module tb_seq_shift_extend;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [15:0] imm_in;
  logic [4:0]  shamt;
  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] result_a, result_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  always #5 clk = ~clk;

  seq_shift_extend #(.WIDTH(32), .IMM_W(16), .STEP(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start_a), .op(op), .data_in(data_in),
    .imm_in(imm_in), .shamt(shamt), .busy(busy_a), .done(done_a), .result(result_a)
  );

  seq_shift_extend #(.WIDTH(32), .IMM_W(16), .STEP(4)) u_dut_b (
    .clk(clk), .rst(rst), .start(start_b), .op(op), .data_in(data_in),
    .imm_in(imm_in), .shamt(shamt), .busy(busy_b), .done(done_b), .result(result_b)
  );

`ifdef SEQ_SHIFT_ROTATE_EN
  localparam bit ROR_EN = 1'b1;
`else
  localparam bit ROR_EN = 1'b0;
`endif

  function automatic bit model_legal(input logic [2:0] o);
    return (o <= 3'd4) || (o == 3'd5 && ROR_EN);
  endfunction

  function automatic logic [31:0] model_result(input logic [2:0] o, input logic [31:0] d,
                                               input logic [15:0] im, input logic [4:0] sh);
    logic [31:0] r;
    case (o)
      3'd0: r = d << sh;
      3'd1: r = d >> sh;
      3'd2: r = $signed(d) >>> sh;
      3'd3: r = {16'h0000, im} << sh;
      3'd4: r = {{16{im[15]}}, im} << sh;
      3'd5: r = ROR_EN ? ((d >> sh) | (d << (6'd32 - {1'b0, sh}))) : d;
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic int model_lat(input logic [2:0] o, input logic [4:0] sh, input int step);
    if (!model_legal(o) || sh == 5'd0) return 1;
    return 1 + (int'(sh) + step - 1) / step;
  endfunction

  task automatic issue(input bit sel, input logic [2:0] o, input logic [31:0] d,
                       input logic [15:0] im, input logic [4:0] sh,
                       input logic [31:0] er, input int el);
    @(posedge clk);
    @(negedge clk);
    op = o; data_in = d; imm_in = im; shamt = sh;
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    exp_q.push_back(er);
    lat_q.push_back(el);
  endtask

  task automatic wait_done(input bit sel, output int cyc, output bit timeout);
    cyc = 0;
    timeout = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk);
      #1;
      start_a = 1'b0;
      start_b = 1'b0;
      if ((sel ? done_b : done_a) === 1'b1) begin
        cyc = i;
        timeout = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0;
    op = '0; data_in = '0; imm_in = '0; shamt = '0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset busy_a: got %b expected 0", busy_a); end
    n_tests++; if (done_a !== 1'b0) begin n_fail++; $display("FAIL reset done_a: got %b expected 0", done_a); end
    n_tests++; if (result_a !== 32'h0) begin n_fail++; $display("FAIL reset result_a: got %h expected 0", result_a); end
    n_tests++; if (busy_b !== 1'b0 || done_b !== 1'b0 || result_b !== 32'h0) begin
      n_fail++; $display("FAIL reset dut_b: busy %b done %b result %h expected 0/0/0", busy_b, done_b, result_b);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_sll_long;
    int cyc;
    bit busy_ok;
    logic [31:0] er;
    int el;
    busy_ok = 1'b1;
    cyc = 0;
    issue(1'b0, 3'd0, 32'h0000_0001, 16'h0, 5'd31, 32'h8000_0000, 32);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      start_a = 1'b0;
      if (busy_a !== 1'b1) busy_ok = 1'b0;
      if (done_a === 1'b1) begin cyc = i; break; end
    end
    er = exp_q.pop_front();
    el = lat_q.pop_front();
    n_tests++; if (result_a !== er) begin n_fail++; $display("FAIL sll31 result: got %h expected %h", result_a, er); end
    n_tests++; if (cyc != el) begin n_fail++; $display("FAIL sll31 latency: got %0d expected %0d", cyc, el); end
    n_tests++; if (!busy_ok) begin n_fail++; $display("FAIL sll31 busy: dropped before done, expected high edges 1-%0d", el); end
    @(posedge clk);
    #1;
    n_tests++; if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_fail++; $display("FAIL sll31 after done: busy %b done %b expected 0/0", busy_a, done_a);
    end
    n_tests++; if (result_a !== er) begin n_fail++; $display("FAIL sll31 hold: got %h expected %h", result_a, er); end
  endtask

  typedef struct {
    bit          sel;
    logic [2:0]  op;
    logic [31:0] d;
    logic [15:0] im;
    logic [4:0]  sh;
    logic [31:0] r;
    int          lat;
  } vec_t;

  task automatic test_directed;
    vec_t tbl[8];
    int cyc;
    bit to;
    logic [31:0] er, res;
    int el;
    tbl[0] = '{1'b0, 3'd2, 32'h8000_0000, 16'h0000, 5'd4, 32'hF800_0000, 5};
    tbl[1] = '{1'b0, 3'd1, 32'h8000_0000, 16'h0000, 5'd4, 32'h0800_0000, 5};
    tbl[2] = '{1'b0, 3'd4, 32'h0000_0000, 16'hFFFC, 5'd2, 32'hFFFF_FFF0, 3};
    tbl[3] = '{1'b0, 3'd3, 32'h0000_0000, 16'h8000, 5'd0, 32'h0000_8000, 1};
    tbl[4] = '{1'b1, 3'd0, 32'h0000_0001, 16'h0000, 5'd5, 32'h0000_0020, 3};
    tbl[5] = '{1'b0, 3'd6, 32'h1234_5678, 16'h0000, 5'd7, 32'h1234_5678, 1};
    tbl[6] = '{1'b1, 3'd7, 32'hCAFE_F00D, 16'h1111, 5'd9, 32'hCAFE_F00D, 1};
`ifdef SEQ_SHIFT_ROTATE_EN
    tbl[7] = '{1'b0, 3'd5, 32'h0000_0003, 16'h0000, 5'd1, 32'h8000_0001, 2};
`else
    tbl[7] = '{1'b0, 3'd5, 32'h0000_0003, 16'h0000, 5'd1, 32'h0000_0003, 1};
`endif
    for (int v = 0; v < 8; v++) begin
      issue(tbl[v].sel, tbl[v].op, tbl[v].d, tbl[v].im, tbl[v].sh, tbl[v].r, tbl[v].lat);
      wait_done(tbl[v].sel, cyc, to);
      er = exp_q.pop_front();
      el = lat_q.pop_front();
      res = tbl[v].sel ? result_b : result_a;
      n_tests++; if (to || res !== er) begin
        n_fail++; $display("FAIL directed[%0d] result: got %h expected %h timeout %0d", v, res, er, to);
      end
      n_tests++; if (cyc != el) begin
        n_fail++; $display("FAIL directed[%0d] latency: got %0d expected %0d", v, cyc, el);
      end
      @(posedge clk);
      #1;
      res = tbl[v].sel ? result_b : result_a;
      n_tests++; if (res !== er) begin
        n_fail++; $display("FAIL directed[%0d] hold: got %h expected %h", v, res, er);
      end
    end
  endtask

  task automatic test_ignore_start;
    int cyc;
    bit extra_done;
    logic [31:0] er;
    int el;
    cyc = 0;
    extra_done = 1'b0;
    issue(1'b0, 3'd0, 32'h0000_0001, 16'h0, 5'd8, 32'h0000_0100, 9);
    for (int i = 1; i <= 60; i++) begin
      @(posedge clk);
      #1;
      start_a = 1'b0;
      if (i == 3) begin
        op = 3'd1; data_in = 32'hFFFF_FFFF; shamt = 5'd1; start_a = 1'b1;
      end
      if (done_a === 1'b1) begin cyc = i; break; end
    end
    er = exp_q.pop_front();
    el = lat_q.pop_front();
    n_tests++; if (result_a !== er) begin n_fail++; $display("FAIL ignore_start result: got %h expected %h", result_a, er); end
    n_tests++; if (cyc != el) begin n_fail++; $display("FAIL ignore_start latency: got %0d expected %0d", cyc, el); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done_a === 1'b1) extra_done = 1'b1;
    end
    n_tests++; if (extra_done) begin n_fail++; $display("FAIL ignore_start queued: got extra done expected none"); end
  endtask

  task automatic test_reset_mid;
    bit saw_done, saw_busy;
    saw_done = 1'b0;
    saw_busy = 1'b0;
    issue(1'b0, 3'd0, 32'h0000_0001, 16'h0, 5'd20, 32'h0010_0000, 21);
    void'(exp_q.pop_front());
    void'(lat_q.pop_front());
    repeat (5) begin
      @(posedge clk);
      #1;
      start_a = 1'b0;
    end
    n_tests++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL reset_mid pre: busy got %b expected 1", busy_a); end
    @(negedge clk);
    rst = 1'b1;
    op = 3'd3; imm_in = 16'h00FF; shamt = 5'd0; start_a = 1'b1;
    @(posedge clk);
    #1;
    n_tests++; if (busy_a !== 1'b0 || done_a !== 1'b0 || result_a !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid: busy %b done %b result %h expected 0/0/0", busy_a, done_a, result_a);
    end
    @(negedge clk);
    rst = 1'b0;
    start_a = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done_a === 1'b1) saw_done = 1'b1;
      if (busy_a === 1'b1) saw_busy = 1'b1;
    end
    n_tests++; if (saw_done || saw_busy) begin
      n_fail++; $display("FAIL reset_mid after: done seen %0d busy seen %0d expected 0/0", saw_done, saw_busy);
    end
    n_tests++; if (result_a !== 32'h0) begin n_fail++; $display("FAIL reset_mid result: got %h expected 0", result_a); end
  endtask

  task automatic test_back_to_back;
    int cyc;
    bit to, sel;
    logic [2:0] o;
    logic [31:0] d, er, res;
    logic [15:0] im;
    logic [4:0] sh;
    int el;
    for (int n = 0; n < 16; n++) begin
      sel = n[0];
      o   = 3'($urandom_range(0, 7));
      d   = $urandom;
      im  = 16'($urandom);
      sh  = 5'($urandom_range(0, 31));
      issue(sel, o, d, im, sh, model_result(o, d, im, sh), model_lat(o, sh, sel ? 4 : 1));
      wait_done(sel, cyc, to);
      er = exp_q.pop_front();
      el = lat_q.pop_front();
      res = sel ? result_b : result_a;
      n_tests++; if (to || res !== er) begin
        n_fail++; $display("FAIL b2b[%0d] op %0d sh %0d result: got %h expected %h", n, o, sh, res, er);
      end
      n_tests++; if (cyc != el) begin
        n_fail++; $display("FAIL b2b[%0d] op %0d sh %0d latency: got %0d expected %0d", n, o, sh, cyc, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sll_long();
    test_directed();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
